// File: rtl/clock_key_ctrl.sv
// -----------------------------------------------------------------------------
// clock_key_ctrl
//
// Key-input controller and RUN/SET sequencer for the digital clock datapath.
// Each raw key passes through a 2-flop synchroniser and a debounce counter
// and produces a one-cycle press event. A RUN/SET_H/SET_M/SET_S state machine
// consumes those events and issues single-cycle inc/dec commands for the
// selected field. It also drives a run enable and a blink enable for the
// display.
//
// Optional feature: define CLOCK_KEY_REPEAT_EN to enable auto-repeat while
// inc/dec is held in a SET state. When it is undefined, no repeat hardware
// is built.
//
// Parameters
//   DEBOUNCE_CYC : cycles a synchronised key must be stable to change level
//   TIMEOUT_CYC  : idle cycles in a SET state before falling back to RUN
//   BLINK_CYC    : half-period of blink in SET states
//   REPEAT_DLY   : hold time before auto-repeat starts (repeat build only)
//   REPEAT_CYC   : auto-repeat pulse spacing (repeat build only)
//
// Ports
//   clk        in  1  system clock
//   rst        in  1  synchronous active-high reset
//   key        in  4  raw async keys: 0=mode 1=exit 2=inc 3=dec
//   field_sel  out 2  0=RUN 1=hour 2=minute 3=second
//   run_en     out 1  high in RUN; the datapath counts only while high
//   inc_pulse  out 1  one-cycle increment for the field in field_sel
//   dec_pulse  out 1  one-cycle decrement for the field in field_sel
//   blink      out 1  display enable for the selected field
// -----------------------------------------------------------------------------
module clock_key_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int TIMEOUT_CYC  = 500_000_000,
    parameter int BLINK_CYC    = 25_000_000,
    parameter int REPEAT_DLY   = 25_000_000,
    parameter int REPEAT_CYC   = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [1:0] field_sel,
    output logic       run_en,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       blink
);

    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC  > 1) ? $clog2(TIMEOUT_CYC)  : 1;
    localparam int BW = (BLINK_CYC    > 1) ? $clog2(BLINK_CYC)    : 1;

    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Per-key synchroniser, debounce and press-event generation
    // -------------------------------------------------------------------------
    logic [3:0] deb_lvl;   // debounced levels
    logic [3:0] press_ev;  // registered one-cycle press events

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic          sync1_q;
            logic          sync2_q;
            logic          deb_q;
            logic          deb_dly_q;
            logic          ev_q;
            logic [DW-1:0] cnt_q;
            logic [DW-1:0] cnt_d;
            logic          deb_d;

            // The counter only runs while the synchronised level disagrees
            // with the debounced level; any agreement restarts the count.
            always_comb begin
                cnt_d = '0;
                deb_d = deb_q;
                if (sync2_q != deb_q) begin
                    if (cnt_q == DEB_MAX) begin
                        deb_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    deb_q     <= 1'b0;
                    deb_dly_q <= 1'b0;
                    ev_q      <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    sync1_q   <= key[gi];
                    sync2_q   <= sync1_q;
                    deb_q     <= deb_d;
                    deb_dly_q <= deb_q;
                    // Rising edge of the debounced level only; releases are silent.
                    ev_q      <= deb_q & ~deb_dly_q;
                    cnt_q     <= cnt_d;
                end
            end

            assign deb_lvl[gi]  = deb_q;
            assign press_ev[gi] = ev_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Event arbitration: exit > mode > inc/dec
    // -------------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    logic mode_ev;
    logic exit_ev;
    logic inc_ev;
    logic dec_ev;
    logic in_set;
    logic exit_acc;
    logic mode_acc;
    logic adj_ok;
    logic inc_acc;
    logic dec_acc;
    logic rpt_inc;
    logic rpt_dec;
    logic inc_fire;
    logic dec_fire;
    logic activity;
    logic tmo_hit;
    logic enter_set;

    logic [TW-1:0] tmo_cnt_q;
    logic [BW-1:0] blk_cnt_q;
    logic          blink_q;

    assign mode_ev  = press_ev[0];
    assign exit_ev  = press_ev[1];
    assign inc_ev   = press_ev[2];
    assign dec_ev   = press_ev[3];

    assign in_set   = (state_q != ST_RUN);
    assign exit_acc = in_set & exit_ev;
    // An exit in RUN is ignored and does not block a simultaneous mode press.
    assign mode_acc = mode_ev & ~exit_acc;
    assign adj_ok   = in_set & ~exit_ev & ~mode_ev;
    // Simultaneous inc and dec cancel each other.
    assign inc_acc  = adj_ok & inc_ev & ~dec_ev;
    assign dec_acc  = adj_ok & dec_ev & ~inc_ev;

    assign inc_fire = inc_acc | rpt_inc;
    assign dec_fire = dec_acc | rpt_dec;
    assign activity = exit_acc | mode_acc | inc_fire | dec_fire;
    // Any activity in the same cycle restarts the idle window instead.
    assign tmo_hit  = in_set & (tmo_cnt_q == TMO_MAX) & ~activity;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (exit_acc) begin
            state_d = ST_RUN;
        end else if (mode_acc) begin
            state_d = state_t'(state_q + 2'd1);  // SET_S wraps back to RUN
        end else if (tmo_hit) begin
            state_d = ST_RUN;
        end
    end

    assign enter_set = (state_d != ST_RUN) && (state_d != state_q);

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        field_sel = state_q;
        run_en    = (state_q == ST_RUN);
        inc_pulse = inc_fire;
        dec_pulse = dec_fire;
        // The pulse cycle itself is forced visible as well as the cycles after.
        blink     = ~in_set | inc_fire | dec_fire | blink_q;
    end

    // -------------------------------------------------------------------------
    // Idle timeout counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (!in_set || activity || enter_set || tmo_cnt_q == TMO_MAX) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Blink generator
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q   <= 1'b1;
            blk_cnt_q <= '0;
        end else if (!in_set || enter_set || inc_fire || dec_fire) begin
            blink_q   <= 1'b1;
            blk_cnt_q <= '0;
        end else if (blk_cnt_q == BLK_MAX) begin
            blink_q   <= ~blink_q;
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Auto-repeat
    // -------------------------------------------------------------------------
`ifdef CLOCK_KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] CYC_MAX = RW'(REPEAT_CYC - 1);

    logic          rpt_arm_q;    // a held inc/dec is being tracked
    logic          rpt_dir_q;    // 0 = inc, 1 = dec
    logic          rpt_phase_q;  // 0 = initial delay, 1 = repeating
    logic [RW-1:0] rpt_cnt_q;
    logic          hold_lvl;
    logic [RW-1:0] rpt_lim;
    logic          rpt_hit;

    assign hold_lvl = rpt_dir_q ? deb_lvl[3] : deb_lvl[2];
    assign rpt_lim  = rpt_phase_q ? CYC_MAX : DLY_MAX;
    // Gated by the live debounced level so pulses stop as soon as it falls.
    assign rpt_hit  = rpt_arm_q & hold_lvl & adj_ok & (rpt_cnt_q == rpt_lim);
    assign rpt_inc  = rpt_hit & ~rpt_dir_q;
    assign rpt_dec  = rpt_hit &  rpt_dir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_arm_q   <= 1'b0;
            rpt_dir_q   <= 1'b0;
            rpt_phase_q <= 1'b0;
            rpt_cnt_q   <= '0;
        end else if (inc_acc || dec_acc) begin
            rpt_arm_q   <= 1'b1;
            rpt_dir_q   <= dec_acc;
            rpt_phase_q <= 1'b0;
            rpt_cnt_q   <= '0;
        end else if (rpt_arm_q) begin
            if (!hold_lvl || mode_ev || exit_ev || !in_set) begin
                rpt_arm_q   <= 1'b0;
                rpt_phase_q <= 1'b0;
                rpt_cnt_q   <= '0;
            end else if (rpt_hit) begin
                rpt_phase_q <= 1'b1;
                rpt_cnt_q   <= '0;
            end else begin
                rpt_cnt_q   <= rpt_cnt_q + 1'b1;
            end
        end
    end
`else
    logic unused_rpt_cfg;

    assign rpt_inc        = 1'b0;
    assign rpt_dec        = 1'b0;
    // Repeat configuration and held levels have no consumer in this build.
    assign unused_rpt_cfg = (^deb_lvl) ^ (REPEAT_DLY > 0) ^ (REPEAT_CYC > 0);
`endif

endmodule

// File: tb/tb_clock_key_ctrl.sv
// Testbench for clock_key_ctrl. An expected-pulse scoreboard is filled as
// stimulus is driven; a negedge monitor pops and compares each pulse the DUT
// emits. Scenario tasks check state/blink inline.
module tb_clock_key_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 200;
    localparam int BLK = 8;
    localparam int LAT = DEB + 3;  // key drive -> event pulse, in edges

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'b0000;
    logic [1:0] field_sel;
    logic       run_en;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       blink;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        bit         dec;
        logic [1:0] field;
    } exp_t;

    exp_t exp_q[$];

    clock_key_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .TIMEOUT_CYC (TMO),
        .BLINK_CYC   (BLK),
        .REPEAT_DLY  (30),
        .REPEAT_CYC  (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .field_sel(field_sel),
        .run_en   (run_en),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (inc_pulse === 1'b1 || dec_pulse === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d inc=%b dec=%b field=%0d want none",
                         cyc, inc_pulse, dec_pulse, field_sel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc !== e.cyc || dec_pulse !== e.dec || inc_pulse !== !e.dec ||
                    field_sel !== e.field) begin
                    errors++;
                    $display("FAIL pulse got cyc=%0d inc=%b dec=%b field=%0d want cyc=%0d dec=%b field=%0d",
                             cyc, inc_pulse, dec_pulse, field_sel, e.cyc, e.dec, e.field);
                end else begin
                    $display("pulse ok cyc=%0d %s field=%0d", cyc, e.dec ? "dec" : "inc", e.field);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d want finish", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx, input int hold, input int idle);
        key[idx] = 1'b1;
        tick(hold);
        key[idx] = 1'b0;
        tick(idle);
    endtask

    // Press an adjust key and register the pulse it should produce.
    task automatic press_adj(input bit dec, input logic [1:0] field, input int hold);
        exp_t e;
        e.cyc = cyc + LAT; e.dec = dec; e.field = field;
        exp_q.push_back(e);
        press(dec ? 3 : 2, hold, 12);
    endtask

    task automatic chk_field(input string name, input logic [1:0] want);
        checks++;
        if (field_sel !== want) begin
            errors++;
            $display("FAIL %s field_sel got %0d want %0d", name, field_sel, want);
        end else begin
            $display("check %s field_sel=%0d", name, field_sel);
        end
    endtask

    task automatic chk_blink(input string name, input logic want);
        checks++;
        if (blink !== want) begin
            errors++;
            $display("FAIL %s blink got %b want %b", name, blink, want);
        end
    endtask

    task automatic chk_queue(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_pulses got %0d pending want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key = 4'b0000;
        tick(3);
        chk_field("reset", 2'd0);
        checks++;
        if (run_en !== 1'b1 || inc_pulse !== 1'b0 || dec_pulse !== 1'b0 || blink !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got run_en=%b inc=%b dec=%b blink=%b want 1 0 0 1",
                     run_en, inc_pulse, dec_pulse, blink);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_run_ignore;
        press(2, 100, 12);
        chk_field("run_inc_ignored", 2'd0);
        checks++;
        if (run_en !== 1'b1) begin
            errors++;
            $display("FAIL run_en_in_run got %b want 1", run_en);
        end
    endtask

    task automatic test_mode_cycle;
        int c;
        c = cyc;
        key[0] = 1'b1;
        tick(LAT);
        checks++;
        if (cyc !== c + LAT || field_sel !== 2'd0) begin
            errors++;
            $display("FAIL mode_early got field=%0d want 0", field_sel);
        end
        tick(1);
        checks++;
        if (field_sel !== 2'd1 || run_en !== 1'b0) begin
            errors++;
            $display("FAIL mode_latency got field=%0d run_en=%b want 1 0", field_sel, run_en);
        end
        tick(20 - LAT - 1);
        key[0] = 1'b0;
        tick(12);
        press(0, 20, 12);
        chk_field("mode_set_m", 2'd2);
        press(0, 20, 12);
        chk_field("mode_set_s", 2'd3);
        press(0, 20, 12);
        chk_field("mode_wrap", 2'd0);
        chk_blink("blink_run", 1'b1);
    endtask

    task automatic test_inc_hold;
        int c;
        exp_t e;
        press(0, 20, 12);
        press(0, 20, 12);
        chk_field("enter_set_m", 2'd2);
        c = cyc;
        e.cyc = c + LAT; e.dec = 1'b0; e.field = 2'd2;
        exp_q.push_back(e);
        key[2] = 1'b1;
        tick(LAT);
        chk_blink("blink_at_pulse", 1'b1);
        tick(BLK);
        chk_blink("blink_hold_hi", 1'b1);
        tick(1);
        chk_blink("blink_first_low", 1'b0);
        tick(BLK - 1);
        chk_blink("blink_hold_lo", 1'b0);
        tick(1);
        chk_blink("blink_back_hi", 1'b1);
        tick(100 - (LAT + 2 * BLK + 1));
        key[2] = 1'b0;
        tick(12);
        chk_field("after_inc_hold", 2'd2);
        chk_queue("inc_hold");
        press(0, 0, 0);  // no-op keeps key idle
        press(1, 20, 12);
        chk_field("exit_from_set_m", 2'd0);
    endtask

    task automatic test_bounce;
        press(0, 20, 12);
        for (int i = 0; i < 5; i++) begin
            key[3] = 1'b1;
            tick(2);
            key[3] = 1'b0;
            tick(2);
        end
        tick(10);
        key[3:2] = 2'b11;
        tick(20);
        key[3:2] = 2'b00;
        tick(12);
        chk_field("bounce_state", 2'd1);
        press_adj(1'b1, 2'd1, 20);
        chk_queue("dec_single");
        press(1, 20, 12);
        chk_field("exit_from_set_h", 2'd0);
    endtask

    task automatic test_back_to_back;
        press(0, 20, 12);
        press_adj(1'b0, 2'd1, 8);
        press_adj(1'b0, 2'd1, 8);
        press_adj(1'b1, 2'd1, 8);
        chk_queue("back_to_back");
        press(1, 20, 12);
        chk_field("b2b_exit", 2'd0);
    endtask

    task automatic test_timeout;
        int c;
        c = cyc;
        key[0] = 1'b1;
        tick(20);
        key[0] = 1'b0;
        tick(LAT + 1 + TMO - 1 - 20);
        checks++;
        if (cyc !== c + LAT + TMO || field_sel !== 2'd1) begin
            errors++;
            $display("FAIL timeout_early got cyc=%0d field=%0d want field 1", cyc - c, field_sel);
        end
        tick(1);
        chk_field("timeout_fire", 2'd0);
    endtask

    task automatic test_exit_priority;
        press(0, 20, 12);
        press(0, 20, 12);
        press(0, 20, 12);
        chk_field("enter_set_s", 2'd3);
        key[1:0] = 2'b11;
        tick(LAT);
        chk_field("exit_pending", 2'd3);
        tick(1);
        chk_field("exit_over_mode", 2'd0);
        checks++;
        if (run_en !== 1'b1 || blink !== 1'b1) begin
            errors++;
            $display("FAIL exit_outputs got run_en=%b blink=%b want 1 1", run_en, blink);
        end
        tick(20 - LAT - 1);
        key[1:0] = 2'b00;
        tick(12);
    endtask

`ifdef CLOCK_KEY_REPEAT_EN
    task automatic test_repeat;
        int c;
        exp_t e;
        press(0, 20, 12);
        press(0, 20, 12);
        press(0, 20, 12);
        chk_field("rpt_set_s", 2'd3);
        c = cyc;
        e.dec = 1'b0; e.field = 2'd3;
        e.cyc = c + LAT;
        exp_q.push_back(e);
        for (int t = LAT + 30; t < 100 + 6; t += 10) begin
            e.cyc = c + t;
            exp_q.push_back(e);
        end
        key[2] = 1'b1;
        tick(100);
        key[2] = 1'b0;
        tick(20);
        chk_queue("repeat_hold");
        c = cyc;
        e.cyc = c + LAT;      exp_q.push_back(e);
        e.cyc = c + LAT + 30; exp_q.push_back(e);
        key[2] = 1'b1;
        tick(40);
        rst = 1'b1;
        tick(1);
        chk_field("rpt_reset", 2'd0);
        tick(1);
        rst = 1'b0;
        tick(60);
        key[2] = 1'b0;
        tick(12);
        chk_queue("repeat_reset");
    endtask
`endif

    initial begin
        test_reset();
        test_run_ignore();
        test_mode_cycle();
        test_inc_hold();
        test_bounce();
        test_back_to_back();
        test_timeout();
        test_exit_priority();
`ifdef CLOCK_KEY_REPEAT_EN
        test_repeat();
`endif
        chk_queue("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_key_ctrl.md
# clock_key_ctrl

Key-input controller and set-mode sequencer for the digital clock datapath. It synchronises and debounces the four user keys and runs the RUN/SET state machine. It emits single-cycle increment/decrement commands for the selected time field, plus a run-enable and a display blink signal. The `clock` counter/display datapath consumes these outputs in place of raw keys.

## Interface
- `DEBOUNCE_CYC`, 1_000_000: cycles a synchronised key must stay stable before its debounced level changes (20 ms at 50 MHz).
- `TIMEOUT_CYC`, 500_000_000: idle cycles in a SET state before automatic return to RUN (10 s).
- `BLINK_CYC`, 25_000_000: half-period of `blink` in SET states.
- `REPEAT_DLY`, 25_000_000: hold time before auto-repeat starts. Used only with the macro.
- `REPEAT_CYC`, 5_000_000: auto-repeat pulse spacing. Used only with the macro.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `key` in 4: raw active-high keys, asynchronous. Key 0 = mode, key 1 = exit, key 2 = inc, key 3 = dec.
- `field_sel` out 2: current state/field. 0 = RUN, 1 = hour, 2 = minute, 3 = second.
- `run_en` out 1: high when `field_sel` == 0; the datapath counts time only while high.
- `inc_pulse` out 1: one-cycle increment command for the field selected by `field_sel`.
- `dec_pulse` out 1: one-cycle decrement command for the field selected by `field_sel`.
- `blink` out 1: display enable for the selected field.

## Operation
- Per key: a 2-flop synchroniser, then a debounce counter.
  - The counter clears whenever the synchronised level equals the debounced level.
  - When it reaches `DEBOUNCE_CYC`-1 with the levels still differing, the debounced level flips on the next edge.
  - A press event is a registered one-cycle pulse the cycle after the debounced level rises. Releases generate no event.
- FSM states: RUN(0), SET_H(1), SET_M(2), SET_S(3).
  - Mode press advances RUN→SET_H→SET_M→SET_S→RUN.
  - Exit press in any SET state goes to RUN; in RUN it is ignored.
- Priority within one cycle: exit > mode > inc/dec.
  - inc and dec pressed in the same cycle: neither pulse is emitted.
  - inc/dec are ignored in RUN.
  - An inc/dec pulse is emitted in the cycle its event is accepted; `field_sel` is valid in that same cycle.
- Timeout: a counter clears on every accepted press event and on entering a SET state. Reaching `TIMEOUT_CYC`-1 in a SET state forces RUN on the next edge.
- Blink:
  - In RUN, `blink`=1.
  - On entering a SET state, `blink`=1 and the blink counter clears; `blink` then toggles every `BLINK_CYC` cycles.
  - Every inc/dec pulse forces `blink`=1 and clears the blink counter, so the field is visible while adjusting.
- Counter widths are $clog2 of their parameter, minimum 1 bit.

## Timing
- Reset values:
  - Outputs: `field_sel`=0, `run_en`=1, `inc_pulse`=0, `dec_pulse`=0, `blink`=1.
  - Internals: synchroniser and debounced levels 0; all counters 0.
- Press latency: the event pulse is high exactly `DEBOUNCE_CYC`+3 edges after the first edge that samples the key high. The resulting state change is visible on `field_sel` one edge later.
- Bounce: any glitch shorter than `DEBOUNCE_CYC` cycles produces no event.
- Reset mid-operation: immediate return to RUN on the next edge. Pending debounce/timeout/repeat progress is discarded.
- A key held high through reset release produces one press event `DEBOUNCE_CYC`+3 edges after release.

## Configuration
- `CLOCK_KEY_REPEAT_EN` defined:
  - Holding inc or dec in a SET state yields the initial pulse.
  - After `REPEAT_DLY` further cycles of debounced-high, a further pulse is emitted every `REPEAT_CYC` cycles until release.
  - Each repeat pulse counts as activity for the timeout and blink rules.
  - A mode/exit event cancels repeat.
- Undefined: exactly one pulse per press; repeat counters are not built.

## Test plan
- Reset with key=0; `DEBOUNCE_CYC`=4, `TIMEOUT_CYC`=200, `BLINK_CYC`=8 → outputs at reset values. key[2] held 100 cycles in RUN → no `inc_pulse`; `field_sel` stays 0.
- key[0] pressed 20 cycles → `field_sel`=1, `run_en`=0 exactly 8 edges after first sample. Two more presses → `field_sel`=3. Fourth press → `field_sel`=0.
- In SET_M, key[2] held 100 cycles → exactly one `inc_pulse` (without macro) with `field_sel`=2. `blink` goes 1 then toggles every 8 cycles after the pulse.
- key[3] toggled every 2 cycles for 20 cycles → no `dec_pulse`. key[2] and key[3] rising on the same edge → neither pulse.
- In SET_H, no keys for 200 cycles → `field_sel`=0 at cycle 200. Exit (key[1]) in SET_S → `field_sel`=0 regardless of a simultaneous key[0] press.
- With `CLOCK_KEY_REPEAT_EN`, `REPEAT_DLY`=30, `REPEAT_CYC`=10: key[2] held 100 cycles in SET_S → pulses at 0, +30, +40, +50, …, stopping within one cycle of debounced release. `rst` asserted mid-hold → `field_sel`=0 next edge and no further pulses.
